// File: rtl/mem_responder_if.sv
// Processor memory bus plus boot-loader port between the core/loader and mem_responder.
// master: processor and loader side; slave: the responder.
interface mem_responder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             memRead;
    logic             memWrite;
    logic [WIDTH-1:0] adrToMem;
    logic [WIDTH-1:0] dataToMem;
    logic [WIDTH-1:0] dataFromMem;
    logic [WIDTH-1:0] loadedAdr;
    logic             cpuHold;
    logic             ldValid;
    logic             ldReady;
    logic [WIDTH-1:0] ldAdr;
    logic [WIDTH-1:0] ldData;
    logic             ldDone;

    modport master (
        output memRead, memWrite, adrToMem, dataToMem,
        output ldValid, ldAdr, ldData, ldDone,
        input  dataFromMem, loadedAdr, cpuHold, ldReady
    );

    modport slave (
        input  memRead, memWrite, adrToMem, dataToMem,
        input  ldValid, ldAdr, ldData, ldDone,
        output dataFromMem, loadedAdr, cpuHold, ldReady
    );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data RAM with boot-load sequencing and a fixed-latency read path.
// The processor is held while the loader fills the RAM, then released to run.
module mem_responder #(
    parameter int unsigned     WIDTH        = 16,
    parameter int unsigned     ADDR_BITS    = 10,
    parameter int unsigned     READ_LATENCY = 1,
    parameter logic [WIDTH-1:0] BOOT_ADR    = '0
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned PIPE  = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic [WIDTH-1:0]     ram [DEPTH];
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_wadr;
    logic [WIDTH-1:0]     ram_wdata;
    logic                 rd_issue;
    logic                 boot_load;
    logic                 hold_next;
    logic [ADDR_BITS-1:0] cpu_adr;
    logic                 unused_upper;

    // Addresses wrap: only the low ADDR_BITS select a word.
    assign cpu_adr      = bus.adrToMem[ADDR_BITS-1:0];
    assign unused_upper = ^bus.adrToMem[WIDTH-1:ADDR_BITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_next;
    end

    // Next state and per-cycle actions; a simultaneous read+write is a write only.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_wadr   = cpu_adr;
        ram_wdata  = bus.dataToMem;
        rd_issue   = 1'b0;
        boot_load  = 1'b0;
        case (state)
            LOAD: begin
                if (bus.ldValid) begin
                    if (bus.ldDone) begin
                        boot_load  = 1'b1;
                        state_next = RUN;
                    end else begin
                        ram_we    = 1'b1;
                        ram_wadr  = bus.ldAdr[ADDR_BITS-1:0];
                        ram_wdata = bus.ldData;
                    end
                end
            end
            RUN: begin
                if (bus.memWrite)     ram_we   = 1'b1;
                else if (bus.memRead) rd_issue = 1'b1;
            end
            default: state_next = LOAD;
        endcase
        hold_next = (state_next == LOAD);
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wadr] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cpuHold   <= 1'b1;
            bus.ldReady   <= 1'b1;
            bus.loadedAdr <= BOOT_ADR;
        end else begin
            bus.cpuHold <= hold_next;
            bus.ldReady <= hold_next;
            if (boot_load) bus.loadedAdr <= bus.ldAdr;
        end
    end

    generate
        if (READ_LATENCY <= 1) begin : g_direct
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)        bus.dataFromMem <= '0;
                else if (rd_issue) bus.dataFromMem <= ram[cpu_adr];
            end
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_data [PIPE];
            logic [PIPE-1:0]  pipe_valid;

            // Data stages carry no reset; only the valid bits are flushed.
            always_ff @(posedge clk) begin
                pipe_data[0] <= ram[cpu_adr];
                for (int i = 1; i < int'(PIPE); i++) pipe_data[i] <= pipe_data[i-1];
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pipe_valid      <= '0;
                    bus.dataFromMem <= '0;
                end else begin
                    pipe_valid[0] <= rd_issue;
                    for (int i = 1; i < int'(PIPE); i++) pipe_valid[i] <= pipe_valid[i-1];
                    if (pipe_valid[PIPE-1]) bus.dataFromMem <= pipe_data[PIPE-1];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (read latency 1, 2, 3) share one stimulus
// stream and are checked against a word-array memory model with an issue-edge read log.
module tb_mem_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        mem_read, mem_write, ld_valid, ld_done;
    logic [15:0] adr, wdata, ld_adr, ld_data;

    mem_responder_if #(.WIDTH(16)) bus1 ();
    mem_responder_if #(.WIDTH(16)) bus2 ();
    mem_responder_if #(.WIDTH(16)) bus3 ();

    mem_responder #(.WIDTH(16), .ADDR_BITS(10), .READ_LATENCY(1), .BOOT_ADR(16'h0000))
        dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
    mem_responder #(.WIDTH(16), .ADDR_BITS(10), .READ_LATENCY(2), .BOOT_ADR(16'h0000))
        dut2 (.clk(clk), .reset(rst_n), .bus(bus2));
    mem_responder #(.WIDTH(16), .ADDR_BITS(10), .READ_LATENCY(3), .BOOT_ADR(16'h0000))
        dut3 (.clk(clk), .reset(rst_n), .bus(bus3));

    assign bus1.memRead = mem_read;  assign bus2.memRead = mem_read;  assign bus3.memRead = mem_read;
    assign bus1.memWrite = mem_write; assign bus2.memWrite = mem_write; assign bus3.memWrite = mem_write;
    assign bus1.adrToMem = adr;      assign bus2.adrToMem = adr;      assign bus3.adrToMem = adr;
    assign bus1.dataToMem = wdata;   assign bus2.dataToMem = wdata;   assign bus3.dataToMem = wdata;
    assign bus1.ldValid = ld_valid;  assign bus2.ldValid = ld_valid;  assign bus3.ldValid = ld_valid;
    assign bus1.ldAdr = ld_adr;      assign bus2.ldAdr = ld_adr;      assign bus3.ldAdr = ld_adr;
    assign bus1.ldData = ld_data;    assign bus2.ldData = ld_data;    assign bus3.ldData = ld_data;
    assign bus1.ldDone = ld_done;    assign bus2.ldDone = ld_done;    assign bus3.ldDone = ld_done;

    logic [15:0] dout [3];
    logic [15:0] ladr [3];
    logic        hold [3];
    logic        rdy  [3];
    assign dout[0] = bus1.dataFromMem; assign dout[1] = bus2.dataFromMem; assign dout[2] = bus3.dataFromMem;
    assign ladr[0] = bus1.loadedAdr;   assign ladr[1] = bus2.loadedAdr;   assign ladr[2] = bus3.loadedAdr;
    assign hold[0] = bus1.cpuHold;     assign hold[1] = bus2.cpuHold;     assign hold[2] = bus3.cpuHold;
    assign rdy[0]  = bus1.ldReady;     assign rdy[1]  = bus2.ldReady;     assign rdy[2]  = bus3.ldReady;

    // Reference model: memory words, the read value logged at each issue edge, and booted flag.
    logic [15:0] mram [1024];
    logic [15:0] rd_at [int];
    logic [15:0] exp_out [3];
    bit          m_run;
    logic [15:0] m_loaded;
    int          edge_cnt;
    int          n_checks;
    int          n_fail;
    logic [15:0] rnd_adr [6];
    logic [15:0] rnd_dat [6];

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; adr = '0; wdata = '0;
        ld_valid = 1'b0; ld_done = 1'b0; ld_adr = '0; ld_data = '0;
    endtask

    task automatic model_reset();
        rd_at.delete();
        for (int i = 0; i < 3; i++) exp_out[i] = '0;
        m_run    = 1'b0;
        m_loaded = 16'h0000;
    endtask

    // Apply current inputs to the model, run one clock, sample after the falling edge.
    // A read issued at edge e reaches the latency-L output at edge e+L-1.
    task automatic tick();
        int e;
        e = edge_cnt + 1;
        if (rst_n) begin
            if (!m_run) begin
                if (ld_valid && ld_done) begin
                    m_loaded = ld_adr;
                    m_run    = 1'b1;
                end else if (ld_valid) begin
                    mram[ld_adr[9:0]] = ld_data;
                end
            end else if (mem_write) begin
                mram[adr[9:0]] = wdata;
            end else if (mem_read) begin
                rd_at[e] = mram[adr[9:0]];
            end
        end
        @(posedge clk);
        edge_cnt = e;
        if (rst_n)
            for (int i = 0; i < 3; i++)
                if (rd_at.exists(e - i)) exp_out[i] = rd_at[e - i];
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        model_reset();
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dout[i] !== 16'h0000 || hold[i] !== 1'b1 || rdy[i] !== 1'b1 || ladr[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset L%0d dout=%h hold=%b rdy=%b ladr=%h want 0000/1/1/0000",
                         i + 1, dout[i], hold[i], rdy[i], ladr[i]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hold[i] !== 1'b1 || rdy[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release L%0d hold=%b rdy=%b want 1/1", i + 1, hold[i], rdy[i]);
            end
        end
    endtask

    task automatic test_load_boot();
        logic [15:0] la [3];
        logic [15:0] ld [3];
        la[0] = 16'h0000; la[1] = 16'h0001; la[2] = 16'h0006;
        ld[0] = 16'h1234; ld[1] = 16'hABCD; ld[2] = 16'h6666;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_adr = la[k]; ld_data = ld[k];
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            rnd_adr[k] = {6'($urandom), 10'(16'h0200 + k)};
            rnd_dat[k] = 16'($urandom);
            ld_valid = 1'b1; ld_adr = rnd_adr[k]; ld_data = rnd_dat[k];
            tick();
        end
        idle_inputs();
        ld_adr = 16'h0001; ld_data = 16'hFFFF;
        tick();
        idle_inputs();
        mem_write = 1'b1; adr = 16'h0006; wdata = 16'h0BAD;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hold[i] !== 1'b1 || rdy[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL load_hold L%0d hold=%b rdy=%b want 1/1", i + 1, hold[i], rdy[i]);
            end
        end
        idle_inputs();
        ld_valid = 1'b1; ld_done = 1'b1; ld_adr = 16'h0000; ld_data = 16'hFFFF;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hold[i] !== 1'b0 || rdy[i] !== 1'b0 || ladr[i] !== 16'h0000 || dout[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL boot L%0d hold=%b rdy=%b ladr=%h dout=%h want 0/0/0000/0000",
                         i + 1, hold[i], rdy[i], ladr[i], dout[i]);
            end
        end
    endtask

    task automatic test_latency();
        mem_read = 1'b1; adr = 16'h0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            idle_inputs();
            for (int i = 0; i < 3; i++) begin
                logic [15:0] want;
                want = (c >= i) ? 16'hABCD : 16'h0000;
                n_checks++;
                if (dout[i] !== want) begin
                    n_fail++;
                    $display("FAIL latency L%0d cyc%0d dout=%h want %h", i + 1, c, dout[i], want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra [3];
        logic [15:0] rv [3];
        ra[0] = 16'h0000; ra[1] = 16'h0001; ra[2] = 16'h0000;
        rv[0] = 16'h1234; rv[1] = 16'hABCD; rv[2] = 16'h1234;
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c < 3) begin mem_read = 1'b1; adr = ra[c]; end
            tick();
            for (int i = 0; i < 3; i++) begin
                int k;
                k = c - i;
                n_checks++;
                if ((k >= 0 && k < 3 && dout[i] !== rv[k]) || dout[i] !== exp_out[i]) begin
                    n_fail++;
                    $display("FAIL b2b L%0d cyc%0d dout=%h want %h", i + 1, c, dout[i], exp_out[i]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        mem_read = 1'b1; mem_write = 1'b1; adr = 16'h0005; wdata = 16'h5555;
        tick();
        idle_inputs();
        mem_read = 1'b1; adr = 16'h0005;
        for (int c = 1; c < 5; c++) begin
            tick();
            idle_inputs();
            for (int i = 0; i < 3; i++) begin
                logic [15:0] want;
                want = (c >= i + 1) ? 16'h5555 : 16'h1234;
                n_checks++;
                if (dout[i] !== want) begin
                    n_fail++;
                    $display("FAIL collision_raw L%0d cyc%0d dout=%h want %h", i + 1, c, dout[i], want);
                end
            end
        end
    endtask

    task automatic test_wrap_ignore();
        logic [15:0] ra [2];
        logic [15:0] rv [2];
        mem_write = 1'b1; adr = 16'h0403; wdata = 16'h7777;
        tick();
        idle_inputs();
        ld_valid = 1'b1; ld_adr = 16'h0003; ld_data = 16'h0000;
        tick();
        ld_done = 1'b1; ld_adr = 16'h0055;
        tick();
        idle_inputs();
        ra[0] = 16'h0003; rv[0] = 16'h7777;
        ra[1] = 16'h0006; rv[1] = 16'h6666;
        for (int r = 0; r < 2; r++) begin
            mem_read = 1'b1; adr = ra[r];
            tick();
            idle_inputs();
            tick(); tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (dout[i] !== rv[r] || hold[i] !== 1'b0 || ladr[i] !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL wrap_ignore L%0d adr=%h dout=%h hold=%b ladr=%h want %h/0/0000",
                             i + 1, ra[r], dout[i], hold[i], ladr[i], rv[r]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            mem_read = 1'b1; adr = rnd_adr[k];
            tick();
            idle_inputs();
            tick(); tick();
            n_checks++;
            if (dout[2] !== rnd_dat[k]) begin
                n_fail++;
                $display("FAIL load_readback adr=%h dout=%h want %h", rnd_adr[k], dout[2], rnd_dat[k]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            mem_write = 1'b1; adr = {6'($urandom), 10'(16'h0100 + k)}; wdata = 16'($urandom);
            tick();
        end
        for (int c = 0; c < 150; c++) begin
            int op;
            op = int'($urandom_range(0, 3));
            idle_inputs();
            adr   = {6'($urandom), 6'h04, 4'($urandom)};
            wdata = 16'($urandom);
            mem_write = (op == 1 || op == 3);
            mem_read  = (op == 2 || op == 3);
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (dout[i] !== exp_out[i]) begin
                    n_fail++;
                    $display("FAIL random L%0d cyc%0d dout=%h want %h", i + 1, c, dout[i], exp_out[i]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [15:0] ra [3];
        mem_read = 1'b1; adr = 16'h0001;
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dout[i] !== 16'h0000 || hold[i] !== 1'b1 || rdy[i] !== 1'b1 || ladr[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_mid L%0d dout=%h hold=%b rdy=%b ladr=%h want 0000/1/1/0000",
                         i + 1, dout[i], hold[i], rdy[i], ladr[i]);
            end
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dout[i] !== 16'h0000 || hold[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_flush L%0d dout=%h hold=%b want 0000/1", i + 1, dout[i], hold[i]);
            end
        end
        ld_valid = 1'b1; ld_done = 1'b1; ld_adr = 16'h0123;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ladr[i] !== 16'h0123 || hold[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reboot L%0d ladr=%h hold=%b want 0123/0", i + 1, ladr[i], hold[i]);
            end
        end
        ra[0] = 16'h0005; ra[1] = 16'h0000; ra[2] = 16'h0403;
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c < 3) begin mem_read = 1'b1; adr = ra[c]; end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (dout[i] !== exp_out[i]) begin
                    n_fail++;
                    $display("FAIL retained L%0d cyc%0d dout=%h want %h", i + 1, c, dout[i], exp_out[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dout[i] !== 16'h7777) begin
                n_fail++;
                $display("FAIL retained_final L%0d dout=%h want 7777", i + 1, dout[i]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_cnt = 0;
        test_reset();
        test_load_boot();
        test_latency();
        test_back_to_back();
        test_collision();
        test_wrap_ignore();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
